fma16_mul_seq: RTL and testbench

FMA16_MUL_SEQ -- requirements
Module: fma16_mul_seq

---
 rtl/fma16_mul_seq.sv | 233 +++++++++++++++++++++++
 tb/tb_fma16_mul_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fma16_mul_seq.sv
// fma16_mul_seq: sequential fp16 significand multiplier front end for the FMA16 datapath.
// Computes sign, biased exponent sum, raw 22-bit significand product (radix-2
// shift-and-add, one partial product per cycle) and product class flags.
// Optional feature macro: FMA16_MUL_BYPASS_EN -- when defined, operations whose
// operands are zero/inf/nan skip the iterations and finish one cycle after start.
module fma16_mul_seq #(
  parameter int BIAS = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        Xs,
  input  logic        Ys,
  input  logic [4:0]  Xe,
  input  logic [4:0]  Ye,
  input  logic [10:0] Xm,
  input  logic [10:0] Ym,
  input  logic        Xzero,
  input  logic        Yzero,
  input  logic        Xinf,
  input  logic        Yinf,
  input  logic        Xnan,
  input  logic        Ynan,
  input  logic        Xsnan,
  input  logic        Ysnan,
  output logic        busy,
  output logic        done,
  output logic        Ps,
  output logic [6:0]  Pe,
  output logic [21:0] Pm,
  output logic        Pzero,
  output logic        Pinf,
  output logic        Pnan,
  output logic        Pinvalid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_ITER = 4'd10;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [21:0] acc_q;

  // Operand copies taken at acceptance so later input changes cannot disturb the operation
  logic        xs_q, ys_q;
  logic [4:0]  xe_q, ye_q;
  logic [10:0] xm_q, ym_q;
  logic        xzero_q, yzero_q, xinf_q, yinf_q;
  logic        xnan_q, ynan_q, xsnan_q, ysnan_q;

  // Registered outputs
  logic        busy_q, done_q, ps_q;
  logic [6:0]  pe_q;
  logic [21:0] pm_q;
  logic        pzero_q, pinf_q, pnan_q, pinvalid_q;

  // Result terms and next accumulator value
  logic        src_xs, src_ys;
  logic [4:0]  src_xe, src_ye;
  logic        src_xzero, src_yzero, src_xinf, src_yinf;
  logic        src_xnan, src_ynan, src_xsnan, src_ysnan;
  logic        ps_d;
  logic [6:0]  pe_d;
  logic        pnan_d, pinvalid_d, pinf_d, pzero_d;
  logic [21:0] addend;
  logic [21:0] acc_d;
`ifdef FMA16_MUL_BYPASS_EN
  logic        special_in;
`endif

  // Sign/exponent/flag terms come from the live inputs while idle (bypass finishes
  // at the accept edge) and from the captured operands once an operation is in flight;
  // the accumulator adds Xm<<k when bit k of Ym is set.
  always_comb begin
    src_xs    = xs_q;
    src_ys    = ys_q;
    src_xe    = xe_q;
    src_ye    = ye_q;
    src_xzero = xzero_q;
    src_yzero = yzero_q;
    src_xinf  = xinf_q;
    src_yinf  = yinf_q;
    src_xnan  = xnan_q;
    src_ynan  = ynan_q;
    src_xsnan = xsnan_q;
    src_ysnan = ysnan_q;
    if (state_q == IDLE) begin
      src_xs    = Xs;
      src_ys    = Ys;
      src_xe    = Xe;
      src_ye    = Ye;
      src_xzero = Xzero;
      src_yzero = Yzero;
      src_xinf  = Xinf;
      src_yinf  = Yinf;
      src_xnan  = Xnan;
      src_ynan  = Ynan;
      src_xsnan = Xsnan;
      src_ysnan = Ysnan;
    end

    ps_d       = src_xs ^ src_ys;
    pe_d       = {2'b00, src_xe} + {2'b00, src_ye} - 7'(BIAS);
    pnan_d     = src_xnan | src_ynan | (src_xzero & src_yinf) | (src_xinf & src_yzero);
    pinvalid_d = src_xsnan | src_ysnan | (src_xzero & src_yinf) | (src_xinf & src_yzero);
    pinf_d     = (src_xinf | src_yinf) & ~pnan_d;
    pzero_d    = (src_xzero | src_yzero) & ~pnan_d;

    addend = '0;
    if (ym_q[cnt_q]) begin
      addend = {11'd0, xm_q} << cnt_q;
    end
    acc_d = acc_q + addend;
`ifdef FMA16_MUL_BYPASS_EN
    special_in = Xzero | Yzero | Xinf | Yinf | Xnan | Ynan;
`endif
  end

  // Control FSM: accept in IDLE, iterate 11 partial products in MUL, pulse done in DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      xs_q       <= 1'b0;
      ys_q       <= 1'b0;
      xe_q       <= '0;
      ye_q       <= '0;
      xm_q       <= '0;
      ym_q       <= '0;
      xzero_q    <= 1'b0;
      yzero_q    <= 1'b0;
      xinf_q     <= 1'b0;
      yinf_q     <= 1'b0;
      xnan_q     <= 1'b0;
      ynan_q     <= 1'b0;
      xsnan_q    <= 1'b0;
      ysnan_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ps_q       <= 1'b0;
      pe_q       <= '0;
      pm_q       <= '0;
      pzero_q    <= 1'b0;
      pinf_q     <= 1'b0;
      pnan_q     <= 1'b0;
      pinvalid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            xs_q    <= Xs;
            ys_q    <= Ys;
            xe_q    <= Xe;
            ye_q    <= Ye;
            xm_q    <= Xm;
            ym_q    <= Ym;
            xzero_q <= Xzero;
            yzero_q <= Yzero;
            xinf_q  <= Xinf;
            yinf_q  <= Yinf;
            xnan_q  <= Xnan;
            ynan_q  <= Ynan;
            xsnan_q <= Xsnan;
            ysnan_q <= Ysnan;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
`ifdef FMA16_MUL_BYPASS_EN
            if (special_in) begin
              state_q    <= DONE;
              done_q     <= 1'b1;
              ps_q       <= ps_d;
              pe_q       <= pe_d;
              pm_q       <= '0;
              pzero_q    <= pzero_d;
              pinf_q     <= pinf_d;
              pnan_q     <= pnan_d;
              pinvalid_q <= pinvalid_d;
            end else begin
              state_q <= MUL;
            end
`else
            state_q <= MUL;
`endif
          end
        end
        MUL: begin
          acc_q <= acc_d;
          if (cnt_q == LAST_ITER) begin
            state_q    <= DONE;
            done_q     <= 1'b1;
            ps_q       <= ps_d;
            pe_q       <= pe_d;
            pm_q       <= acc_d;
            pzero_q    <= pzero_d;
            pinf_q     <= pinf_d;
            pnan_q     <= pnan_d;
            pinvalid_q <= pinvalid_d;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign Ps       = ps_q;
  assign Pe       = pe_q;
  assign Pm       = pm_q;
  assign Pzero    = pzero_q;
  assign Pinf     = pinf_q;
  assign Pnan     = pnan_q;
  assign Pinvalid = pinvalid_q;

endmodule

// File: tb/tb_fma16_mul_seq.sv
// tb_fma16_mul_seq: table-driven and scoreboarded bench for fma16_mul_seq.
// Honours FMA16_MUL_BYPASS_EN when the design is built with it.
module tb_fma16_mul_seq;

   typedef struct {
      logic        xs, ys;
      logic [4:0]  xe, ye;
      logic [10:0] xm, ym;
      logic [7:0]  cls;
      logic        ps;
      logic [6:0]  pe;
      logic [21:0] pm;
      logic [3:0]  pf;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        Xs = 1'b0, Ys = 1'b0;
   logic [4:0]  Xe = '0, Ye = '0;
   logic [10:0] Xm = '0, Ym = '0;
   logic        Xzero = 1'b0, Yzero = 1'b0, Xinf = 1'b0, Yinf = 1'b0;
   logic        Xnan = 1'b0, Ynan = 1'b0, Xsnan = 1'b0, Ysnan = 1'b0;
   logic        busy, done, Ps, Pzero, Pinf, Pnan, Pinvalid;
   logic [6:0]  Pe;
   logic [21:0] Pm;

   int   compared = 0;
   int   mismatched = 0;
   vec_t expQ[$];
   vec_t tbl[$];
   vec_t lastExp;

   fma16_mul_seq #(.BIAS(15)) dut (
      .clk(clk), .reset(reset), .start(start),
      .Xs(Xs), .Ys(Ys), .Xe(Xe), .Ye(Ye), .Xm(Xm), .Ym(Ym),
      .Xzero(Xzero), .Yzero(Yzero), .Xinf(Xinf), .Yinf(Yinf),
      .Xnan(Xnan), .Ynan(Ynan), .Xsnan(Xsnan), .Ysnan(Ysnan),
      .busy(busy), .done(done), .Ps(Ps), .Pe(Pe), .Pm(Pm),
      .Pzero(Pzero), .Pinf(Pinf), .Pnan(Pnan), .Pinvalid(Pinvalid)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Global watchdog so the bench can never hang
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // One comparison: bumps the counters and reports any difference
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic xs, input logic ys, input logic [4:0] xe,
                               input logic [4:0] ye, input logic [10:0] xm, input logic [10:0] ym,
                               input logic [7:0] cls, input logic ps, input logic [6:0] pe,
                               input logic [21:0] pm, input logic [3:0] pf);
      vec_t v;
      v.xs = xs; v.ys = ys; v.xe = xe; v.ye = ye; v.xm = xm; v.ym = ym;
      v.cls = cls; v.ps = ps; v.pe = pe; v.pm = pm; v.pf = pf;
      return v;
   endfunction

   // cls = {Xzero,Yzero,Xinf,Yinf,Xnan,Ynan,Xsnan,Ysnan}; pf = {Pzero,Pinf,Pnan,Pinvalid}
   function automatic logic isSpecial(input vec_t v);
      return |v.cls[7:2];
   endfunction

   // Reference model used for the random vectors
   function automatic vec_t model(input vec_t v);
      vec_t r;
      int e;
      logic [31:0] eb;
      logic nan, inv;
      r = v;
      r.pm = 22'(v.xm) * 22'(v.ym);
      e = int'(v.xe) + int'(v.ye) - 15;
      eb = e;
      r.pe = eb[6:0];
      r.ps = v.xs ^ v.ys;
      nan = v.cls[3] | v.cls[2] | (v.cls[7] & v.cls[4]) | (v.cls[5] & v.cls[6]);
      inv = v.cls[1] | v.cls[0] | (v.cls[7] & v.cls[4]) | (v.cls[5] & v.cls[6]);
      r.pf = {(v.cls[7] | v.cls[6]) & ~nan, (v.cls[5] | v.cls[4]) & ~nan, nan, inv};
      return r;
   endfunction

   function automatic int expLatency(input vec_t v);
`ifdef FMA16_MUL_BYPASS_EN
      if (isSpecial(v)) return 1;
`endif
      return 12;
   endfunction

   function automatic vec_t adjustExp(input vec_t v);
      vec_t r;
      r = v;
`ifdef FMA16_MUL_BYPASS_EN
      if (isSpecial(v)) r.pm = '0;
`endif
      return r;
   endfunction

   task automatic driveInputs(input vec_t v);
      Xs = v.xs; Ys = v.ys; Xe = v.xe; Ye = v.ye; Xm = v.xm; Ym = v.ym;
      {Xzero, Yzero, Xinf, Yinf, Xnan, Ynan, Xsnan, Ysnan} = v.cls;
   endtask

   task automatic checkResult(input string tag, input vec_t e);
      check({tag, "_Ps"}, 32'(Ps), 32'(e.ps));
      check({tag, "_Pe"}, 32'(Pe), 32'(e.pe));
      check({tag, "_Pm"}, 32'(Pm), 32'(e.pm));
      check({tag, "_flags"}, 32'({Pzero, Pinf, Pnan, Pinvalid}), 32'(e.pf));
   endtask

   // Pops the scoreboard entry for the result currently on the outputs
   task automatic checkOutput();
      vec_t e;
      if (expQ.size() == 0) begin
         check("scoreboard_empty", 32'(1), 32'(0));
      end else begin
         e = expQ.pop_front();
         lastExp = e;
         checkResult("result", e);
      end
   endtask

   // Waits for done from the current cycle number, bounded; returns final cycle number
   task automatic waitDone(inout int n);
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask

   // Issues one operation, checks latency, result and the single-cycle done pulse
   task automatic applyStimulus(input vec_t v);
      int n;
      @(negedge clk);
      driveInputs(v);
      start = 1'b1;
      expQ.push_back(adjustExp(v));
      @(negedge clk);
      start = 1'b0;
      n = 1;
      check("busy_after_accept", 32'(busy), 32'(1));
      waitDone(n);
      check("latency", 32'(n), 32'(expLatency(v)));
      if (done) checkOutput();
      else void'(expQ.pop_front());
      @(negedge clk);
      check("done_single", 32'(done), 32'(0));
      check("busy_idle", 32'(busy), 32'(0));
   endtask

   initial begin
      vec_t a, b, v;
      int n, doneCount;

      tbl.push_back(mk(0,0,15,15,11'h400,11'h400,8'b0000_0000, 0,7'd15,22'h100000,4'b0000));
      tbl.push_back(mk(1,0,15,15,11'h600,11'h600,8'b0000_0000, 1,7'd15,22'h240000,4'b0000));
      tbl.push_back(mk(0,0, 1, 1,11'h001,11'h001,8'b0000_0000, 0,7'h73,22'h000001,4'b0000));
      tbl.push_back(mk(1,1,30,30,11'h7FF,11'h7FF,8'b0000_0000, 0,7'd45,22'h3FF001,4'b0000));
      tbl.push_back(mk(0,1, 1,31,11'h000,11'h400,8'b1001_0000, 1,7'd17,22'h000000,4'b0011));
      tbl.push_back(mk(0,0,31,15,11'h400,11'h500,8'b0010_0000, 0,7'd31,22'h140000,4'b0100));
      tbl.push_back(mk(1,1,31,16,11'h600,11'h400,8'b0000_1000, 0,7'd32,22'h180000,4'b0010));
      tbl.push_back(mk(0,0,15,31,11'h400,11'h500,8'b0000_0101, 0,7'd31,22'h140000,4'b0011));
      tbl.push_back(mk(0,1, 1,20,11'h000,11'h7FF,8'b1000_0000, 1,7'd6, 22'h000000,4'b1000));
      tbl.push_back(mk(0,0,31,31,11'h400,11'h400,8'b0011_0000, 0,7'd47,22'h100000,4'b0100));
      tbl.push_back(mk(0,1,31,31,11'h400,11'h600,8'b0010_0100, 1,7'd47,22'h180000,4'b0010));
      tbl.push_back(mk(0,0,31, 1,11'h400,11'h000,8'b0110_0000, 0,7'd17,22'h000000,4'b0011));
      for (int i = 0; i < 6; i++) begin
         v = mk(1'($urandom_range(0,1)), 1'($urandom_range(0,1)),
                5'($urandom_range(1,30)), 5'($urandom_range(1,30)),
                11'($urandom_range(0,2047)), 11'($urandom_range(0,2047)),
                8'b0, 0, 7'd0, 22'd0, 4'd0);
         tbl.push_back(model(v));
      end

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_Pm", 32'(Pm), 32'(0));
      check("rst_Pe_Ps", 32'({Pe, Ps}), 32'(0));
      check("rst_flags", 32'({Pzero, Pinf, Pnan, Pinvalid}), 32'(0));
      reset = 1'b0;

      // Table-driven vectors
      for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i]);

      // start during MUL and DONE is ignored; in-flight operand changes have no effect
      a = tbl[1];
      b = tbl[3];
      @(negedge clk);
      driveInputs(a);
      start = 1'b1;
      expQ.push_back(adjustExp(a));
      @(negedge clk);
      start = 1'b0;
      n = 1;
      repeat (4) begin @(negedge clk); n++; end
      driveInputs(b);
      start = 1'b1;
      @(negedge clk);
      n++;
      start = 1'b0;
      waitDone(n);
      check("ignore_latency", 32'(n), 32'(12));
      if (done) checkOutput();
      else void'(expQ.pop_front());
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("ignore_done_low", 32'(done), 32'(0));
      check("ignore_busy_low", 32'(busy), 32'(0));
      doneCount = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done || busy) doneCount++;
      end
      check("ignore_no_extra_op", 32'(doneCount), 32'(0));
      checkResult("hold", lastExp);

      // Reset at iteration 5 aborts the operation
      @(negedge clk);
      driveInputs(b);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      #1;
      check("abort_busy", 32'(busy), 32'(0));
      check("abort_done", 32'(done), 32'(0));
      check("abort_Pm", 32'(Pm), 32'(0));
      check("abort_Pe_Ps", 32'({Pe, Ps}), 32'(0));
      check("abort_flags", 32'({Pzero, Pinf, Pnan, Pinvalid}), 32'(0));
      @(negedge clk);
      reset = 1'b0;
      doneCount = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done) doneCount++;
      end
      check("abort_no_done", 32'(doneCount), 32'(0));
      applyStimulus(b);
      applyStimulus(tbl[0]);

      check("scoreboard_drained", 32'(expQ.size()), 32'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
